// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state encoding, reset default and instruction field positions
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        EXEC   = 2'd2,
        HALTED = 2'd3
    } state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int IMM_MSB   = 15;
    localparam int JADDR_MSB = 25;

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: instruction-memory handshake plus datapath execute/control signals
interface pc_sequencer_if;

    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        ex_done;
    logic        br_taken;
    logic        is_jump;
    logic        halt;
    logic [31:0] pc;
    logic        halted;

    modport master (
        output imem_req, instr, instr_valid, pc, halted,
        input  imem_ready, imem_rdata, ex_done, br_taken, is_jump, halt
    );

    modport slave (
        input  imem_req, instr, instr_valid, pc, halted,
        output imem_ready, imem_rdata, ex_done, br_taken, is_jump, halt
    );

endinterface

// File: rtl/branch_target_calc.sv
// branch_target_calc: sequential, branch and jump candidates for the next PC
module branch_target_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic [31:0] branch_target,
    output logic [31:0] jump_target
);

    logic [31:0] imm_word;
    logic [31-JADDR_MSB-1:0] unused_opcode;

    assign unused_opcode = instr[31:JADDR_MSB+1];

    // sign-extended immediate already scaled to a byte offset, then the three candidates
    always_comb begin
        imm_word      = {{(29 - IMM_MSB){instr[IMM_MSB]}}, instr[IMM_MSB:0], 2'b00};
        pc_plus4      = pc + 32'd4;
        branch_target = pc_plus4 + imm_word;
        jump_target   = {pc_plus4[31:JADDR_MSB+3], instr[JADDR_MSB:0], 2'b00};
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle fetch/execute sequencer that owns the program counter
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    pc_sequencer_if.master   bus
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] pc_plus4, branch_target, jump_target, next_pc;
    logic        fetch_hit, retire;

    branch_target_calc u_btc (
        .pc            (pc_q),
        .instr         (instr_q),
        .pc_plus4      (pc_plus4),
        .branch_target (branch_target),
        .jump_target   (jump_target)
    );

    // state, pc, latched instruction and first-EXEC marker
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // next state: fetch waits on memory, execute waits on the datapath, halt is terminal
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   state_d = FETCH;
            FETCH:  state_d = bus.imem_ready ? EXEC : FETCH;
            EXEC:   state_d = bus.ex_done ? (bus.halt ? HALTED : FETCH) : EXEC;
            HALTED: state_d = HALTED;
        endcase
    end

    // datapath registers: instr captured on the accepted fetch, pc advanced only when an instruction retires
    always_comb begin
        fetch_hit     = (state_q == FETCH) && bus.imem_ready;
        retire        = (state_q == EXEC) && bus.ex_done && !bus.halt;
        next_pc       = bus.is_jump ? jump_target : (bus.br_taken ? branch_target : pc_plus4);
        pc_d          = retire ? next_pc : pc_q;
        instr_d       = fetch_hit ? bus.imem_rdata : instr_q;
        instr_valid_d = fetch_hit;
    end

    // outputs decoded from state and registers
    always_comb begin
        bus.imem_req    = (state_q == FETCH);
        bus.halted      = (state_q == HALTED);
        bus.instr_valid = instr_valid_q;
        bus.instr       = instr_q;
        bus.pc          = pc_q;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks against a transaction-level PC model
module tb_pc_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int errors = 0;
    int checks = 0;
    logic [31:0] mpc;
    logic [31:0] last_w;

    pc_sequencer_if bif ();

    pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] w, input bit jmp, input bit br);
        logic [31:0] p4;
        int off;
        p4 = p + 32'd4;
        off = $signed(w[15:0]);
        if (jmp) return (p4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
        if (br) return p4 + 32'(off * 4);
        return p4;
    endfunction

    task automatic idle_inputs();
        bif.imem_ready = 1'b0;
        bif.imem_rdata = '0;
        bif.ex_done    = 1'b0;
        bif.br_taken   = 1'b0;
        bif.is_jump    = 1'b0;
        bif.halt       = 1'b0;
    endtask

    task automatic junk_exec_inputs();
        bif.ex_done  = 1'($urandom_range(1));
        bif.br_taken = 1'($urandom_range(1));
        bif.is_jump  = 1'($urandom_range(1));
        bif.halt     = 1'($urandom_range(1));
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check("rst_pc", bif.pc, 32'h0);
        check("rst_instr", bif.instr, 32'h0);
        check("rst_valid", bif.instr_valid, 0);
        check("rst_req", bif.imem_req, 0);
        check("rst_halted", bif.halted, 0);
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("post_rst_req0", bif.imem_req, 0);
        @(negedge clk);
        check("first_req", bif.imem_req, 1);
        check("first_pc", bif.pc, 32'h0);
        mpc = 32'h0;
        last_w = 32'h0;
    endtask

    task automatic do_instr(input int stall, input logic [31:0] w, input int dly, input bit jmp, input bit br, input bit hlt);
        for (int i = 0; i < stall; i++) begin
            check("stall_req", bif.imem_req, 1);
            check("stall_pc", bif.pc, mpc);
            check("stall_valid", bif.instr_valid, 0);
            bif.imem_ready = 1'b0;
            bif.imem_rdata = $urandom;
            junk_exec_inputs();
            @(negedge clk);
        end
        check("fetch_req", bif.imem_req, 1);
        check("fetch_pc", bif.pc, mpc);
        bif.imem_ready = 1'b1;
        bif.imem_rdata = w;
        junk_exec_inputs();
        @(negedge clk);
        idle_inputs();
        last_w = w;
        check("exec_valid", bif.instr_valid, 1);
        check("exec_instr", bif.instr, w);
        check("exec_req", bif.imem_req, 0);
        check("exec_pc", bif.pc, mpc);
        for (int i = 0; i < dly; i++) begin
            bif.imem_ready = 1'($urandom_range(1));
            bif.imem_rdata = $urandom;
            bif.br_taken   = 1'($urandom_range(1));
            bif.is_jump    = 1'($urandom_range(1));
            bif.halt       = 1'($urandom_range(1));
            @(negedge clk);
            check("wait_valid", bif.instr_valid, 0);
            check("wait_req", bif.imem_req, 0);
            check("wait_pc", bif.pc, mpc);
            check("wait_instr", bif.instr, w);
        end
        bif.imem_ready = 1'($urandom_range(1));
        bif.ex_done    = 1'b1;
        bif.is_jump    = jmp;
        bif.br_taken   = br;
        bif.halt       = hlt;
        @(negedge clk);
        idle_inputs();
        if (hlt) begin
            check("halt_flag", bif.halted, 1);
            check("halt_pc", bif.pc, mpc);
        end else begin
            mpc = ref_next(mpc, w, jmp, br);
            check("next_halted", bif.halted, 0);
            check("next_req", bif.imem_req, 1);
            check("next_pc", bif.pc, mpc);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        idle_inputs();
        #1;
        apply_reset();
        for (int i = 0; i < 3; i++) do_instr(0, $urandom, 0, 0, 0, 0);
        check("seq_pc12", bif.pc, 32'd12);
        do_instr(0, 32'h0800_0040, 0, 1, 0, 0);
        check("jump_0x100", bif.pc, 32'h100);
        do_instr(0, 32'h1000_FFFB, 0, 0, 1, 0);
        check("branch_back", bif.pc, 32'hF0);
        do_instr(0, 32'h0800_0040, 0, 1, 0, 0);
        do_instr(0, 32'h1000_0003, 0, 0, 1, 0);
        check("branch_fwd", bif.pc, 32'h110);
        do_instr(3, $urandom, 5, 0, 0, 0);
        for (int i = 0; i < 40; i++)
            do_instr($urandom_range(3), $urandom, $urandom_range(3), 1'($urandom_range(1)), 1'($urandom_range(1)), 0);
        bif.imem_ready = 1'b0;
        @(negedge clk);
        check("midrst_req_before", bif.imem_req, 1);
        #2;
        apply_reset();
        do_instr(0, 32'h1000_FFFE, 0, 0, 1, 0);
        check("wrap_pre", bif.pc, 32'hFFFF_FFFC);
        do_instr(1, $urandom, 0, 0, 0, 0);
        check("wrap_zero", bif.pc, 32'h0);
        for (int i = 0; i < 8192; i++) do_instr(0, 32'h1000_7FFF, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) do_instr(0, 32'h0, 0, 0, 0, 0);
        check("walk_pc", bif.pc, 32'h4000_0010);
        do_instr(0, 32'h0800_0040, 0, 1, 1, 0);
        check("jump_prio", bif.pc, 32'h4000_0100);
        apply_reset();
        for (int i = 0; i < 8; i++) do_instr(0, $urandom, 0, 0, 0, 0);
        check("pre_halt_pc", bif.pc, 32'h20);
        do_instr(0, 32'h1234_5678, 2, 0, 1, 1);
        for (int i = 0; i < 10; i++) begin
            bif.imem_ready = 1'($urandom_range(1));
            bif.imem_rdata = $urandom;
            junk_exec_inputs();
            @(negedge clk);
            check("hold_halted", bif.halted, 1);
            check("hold_req", bif.imem_req, 0);
            check("hold_pc", bif.pc, 32'h20);
            check("hold_valid", bif.instr_valid, 0);
            check("hold_instr", bif.instr, last_w);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
